// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    localparam int unsigned RETRY_W = 8;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } pll_sup_state_t;

    // Width of a down-counter able to hold the largest of three reload values.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with timeout and
// retry, qualifies lock as stable, then releases the downstream reset.
// Optional macro PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN adds a terminal FAILED state
// after MAX_RETRIES consecutive lock timeouts.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 8
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_count,
    output logic               failed
);

    localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STABLE_CYCLES);

    // Reject parameter values that would make the sequence meaningless.
    if (RST_CYCLES < 1 || MAX_RETRIES < 1) begin : g_param_check
        $error("pll_lock_supervisor: RST_CYCLES and MAX_RETRIES must be >= 1");
    end

    pll_sup_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic               retry_inc;
    logic               expired;
    logic               lk_s;

`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
    localparam int unsigned CONS_W = $clog2(MAX_RETRIES + 1);
    logic [CONS_W-1:0] consec_q, consec_d;
`endif

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    // Next-state, counter reload and retry bookkeeping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - CNT_W'(1);
        retry_inc = 1'b0;
        expired   = (cnt_q <= CNT_W'(1));
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
        consec_d  = consec_q;
`endif
        case (state_q)
            RESET_PLL: begin
                if (expired) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TMO_LOAD;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the expiry cycle still counts as a lock.
                if (lk_s) begin
                    state_d = STABLE;
                    cnt_d   = STB_LOAD;
                end else if (expired) begin
                    retry_inc = 1'b1;
                    state_d   = RESET_PLL;
                    cnt_d     = RST_LOAD;
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
                    consec_d  = consec_q + CONS_W'(1);
                    if (consec_q >= CONS_W'(MAX_RETRIES - 1)) begin
                        state_d = FAILED;
                    end
`endif
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TMO_LOAD;
                end else if (expired) begin
                    state_d = RUN;
                    cnt_d   = '0;
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
                    consec_d = '0;
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lk_s) begin
                    retry_inc = 1'b1;
                    state_d   = RESET_PLL;
                    cnt_d     = RST_LOAD;
                end
            end
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
            FAILED: begin
                cnt_d = cnt_q;
            end
`endif
            default: begin
                state_d = RESET_PLL;
                cnt_d   = RST_LOAD;
            end
        endcase

        retry_d = (retry_inc && (retry_count != '1)) ? retry_count + RETRY_W'(1)
                                                      : retry_count;
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= RST_LOAD;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_count <= retry_d;
            pll_rst     <= (state_d == RESET_PLL) || (state_d == FAILED);
            sys_rst     <= (state_d != RUN);
            ready       <= (state_d == RUN);
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
    // Consecutive-timeout count and terminal failure flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            consec_q <= '0;
            failed   <= 1'b0;
        end else begin
            consec_q <= consec_d;
            failed   <= (state_d == FAILED);
        end
    end
`else
    assign failed = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor (RST=4, TIMEOUT=20, STABLE=8).
// Define PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN to exercise the FAILED path.
module tb_pll_lock_supervisor;

    localparam int unsigned RST_C  = 4;
    localparam int unsigned TMO_C  = 20;
    localparam int unsigned STB_C  = 8;
    localparam int unsigned MAXR_C = 3;
    localparam int          PER    = RST_C + TMO_C;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_count;
    logic       failed;

    typedef struct {
        int          cyc;
        logic [11:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   base;

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TMO_C),
        .STABLE_CYCLES (STB_C),
        .MAX_RETRIES   (MAXR_C)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .retry_count (retry_count),
        .failed      (failed)
    );

    function automatic logic [11:0] obs();
        return {pll_rst, sys_rst, ready, failed, retry_count};
    endfunction

    function automatic logic [11:0] pk(logic pr, logic sr, logic rd, logic fl, logic [7:0] rc);
        return {pr, sr, rd, fl, rc};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        n_tests++;
        if (obs() !== pk(1, 1, 0, 0, 8'd0)) begin
            n_fail++;
            $display("FAIL reset_values cyc=%0d got=%h want=%h", cyc, obs(), pk(1, 1, 0, 0, 8'd0));
        end
        base = cyc;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int   s;
        exp_t e;
        s = base + 14;
        for (int c = base + 1; c <= base + 27; c++) begin
            if (c < base + 4)       sb.push_back('{c, pk(1, 1, 0, 0, 8'd0)});
            else if (c < s + 10)    sb.push_back('{c, pk(0, 1, 0, 0, 8'd0)});
            else                    sb.push_back('{c, pk(0, 0, 1, 0, 8'd0)});
        end
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL nominal cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            pll_locked = (cyc + 1 >= s);
        end
    endtask

    task automatic test_run_loss();
        int   d;
        int   nx;
        exp_t e;
        d = cyc + 2;
        for (int c = cyc + 1; c <= d + 17; c++) begin
            if (c < d + 2)          sb.push_back('{c, pk(0, 0, 1, 0, 8'd0)});
            else if (c < d + 6)     sb.push_back('{c, pk(1, 1, 0, 0, 8'd1)});
            else if (c < d + 15)    sb.push_back('{c, pk(0, 1, 0, 0, 8'd1)});
            else                    sb.push_back('{c, pk(0, 0, 1, 0, 8'd1)});
        end
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL run_loss cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            nx = cyc + 1;
            pll_locked = !(nx >= d && nx < d + 4);
        end
    endtask

    task automatic test_mid_reset();
        int   m;
        exp_t e;
        m = cyc + 1;
        rst = 1'b1;
        pll_locked = 1'b0;
        for (int c = m; c <= m + 4; c++) begin
            if (c < m + 4)  sb.push_back('{c, pk(1, 1, 0, 0, 8'd0)});
            else            sb.push_back('{c, pk(0, 1, 0, 0, 8'd0)});
        end
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL mid_reset cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            rst = 1'b0;
        end
        base = m;
    endtask

    task automatic test_glitch();
        int   g;
        int   nx;
        exp_t e;
        g = base + 6;
        for (int c = cyc + 1; c <= g + 20; c++) begin
            if (c < g + 18) sb.push_back('{c, pk(0, 1, 0, 0, 8'd0)});
            else            sb.push_back('{c, pk(0, 0, 1, 0, 8'd0)});
        end
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL glitch cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            nx = cyc + 1;
            pll_locked = (nx >= g) && !(nx >= g + 5 && nx <= g + 7);
        end
    endtask

    task automatic test_timeout();
        int   t0;
        int   k;
        int   ph;
        exp_t e;
        t0 = cyc + 1;
        rst = 1'b1;
        pll_locked = 1'b0;
        for (int c = t0; c <= t0 + 3 * PER + 12; c++) begin
            k  = (c - t0) / PER;
            ph = (c - t0) % PER;
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
            if (c - t0 >= 3 * PER) sb.push_back('{c, pk(1, 1, 0, 1, 8'd3)});
            else
`endif
            sb.push_back('{c, pk(ph < 4, 1, 0, 0, 8'(k))});
        end
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            rst = 1'b0;
        end
        base = t0;
    endtask

`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
    task automatic test_failed_exit();
        int   r;
        exp_t e;
        r = cyc + 1;
        rst = 1'b1;
        sb.push_back('{r, pk(1, 1, 0, 0, 8'd0)});
        sb.push_back('{r + 3, pk(1, 1, 0, 0, 8'd0)});
        sb.push_back('{r + 4, pk(0, 1, 0, 0, 8'd0)});
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL failed_exit cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
            rst = 1'b0;
        end
    endtask
`else
    task automatic test_saturation();
        int   c;
        exp_t e;
        c = base + 260 * PER + 2;
        sb.push_back('{c, pk(1, 1, 0, 0, 8'd255)});
        while (sb.size() > 0) begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (obs() !== e.val) begin
                    n_fail++;
                    $display("FAIL saturation cyc=%0d got=%h want=%h", cyc, obs(), e.val);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_run_loss();
        test_mid_reset();
        test_glitch();
        test_timeout();
`ifdef PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN
        test_failed_exit();
`else
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Drives the `rst` input of a video-clock PLL and consumes its `locked` output, all in the 50 MHz reference domain. It holds the PLL in reset for a fixed pulse, waits for lock with a timeout and retry, and qualifies lock as stable before releasing a synchronous reset to downstream video logic. Loss of lock while running triggers a full re-acquisition.

## Interface
- `RST_CYCLES`, 16: PLL reset pulse length in `refclk` cycles, ≥1.
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN.
- `MAX_RETRIES`, 8: consecutive timeouts before FAILED; used only with the configuration macro.
- `refclk` in 1: single clock, PLL reference clock.
- `rst` in 1: reset, synchronous and active-high.
- `pll_locked` in 1: PLL lock indicator, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_rst` out 1: downstream reset, active-high.
- `ready` out 1: high only in RUN.
- `retry_count` out 8: saturating count of timeouts plus lock losses in RUN.
- `failed` out 1: high in FAILED (constant 0 without the macro).

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `lk_s` denotes its output. All decisions use `lk_s`.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAILED (FAILED exists only with the macro).
- One down-counter, width `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1)`, is reloaded on every state entry.
- RESET_PLL: `pll_rst`=1. After `RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - `lk_s`=1 goes to STABLE.
  - Counter expiry with `lk_s`=0 counts as a timeout: `retry_count`++, consecutive-timeout count++, go to RESET_PLL.
  - If `lk_s`=1 and expiry occur in the same cycle, lock wins and no retry is counted.
- STABLE: requires `lk_s`=1 for `STABLE_CYCLES` consecutive cycles, then go to RUN and clear the consecutive-timeout count.
  - Any `lk_s`=0 returns to WAIT_LOCK with the timeout reloaded. This is not counted as a retry.
- RUN: `sys_rst`=0, `ready`=1.
  - `lk_s`=0 counts as a lock loss: `retry_count`++, go to RESET_PLL.
- `sys_rst`=1 in every state except RUN.
- `retry_count` saturates at 255 and is cleared only by `rst`.
- `rst` asserted in any state forces the reset values on the next edge. This also clears the synchronizer, the counters and `retry_count`.

## Timing
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `retry_count`=0, `failed`=0. State RESET_PLL, counter loaded with `RST_CYCLES`.
- All outputs are registered. There is no combinational path from `pll_locked` to any output.
- `pll_rst` is high for exactly `RST_CYCLES` cycles per attempt, counted from the first edge with `rst`=0.
- A `pll_locked` rise reaches `lk_s` after 2 edges. `ready` rises `STABLE_CYCLES`+1 edges after `lk_s` rises.
- A `pll_locked` fall in RUN reaches `lk_s` after 2 edges. `sys_rst`=1 and `ready`=0 follow on edge 3, and `pll_rst`=1 on the same edge.
- Glitches shorter than 1 cycle may be missed; that is acceptable because any glitch that is caught is handled per the rules above.

## Configuration
- `PLL_LOCK_SUPERVISOR_FAIL_LIMIT_EN` defined: after `MAX_RETRIES` consecutive timeouts, enter FAILED.
  - FAILED: `pll_rst`=1, `sys_rst`=1, `failed`=1.
  - FAILED is left only by `rst`.
- Undefined: retries continue indefinitely, FAILED and its counter are not built, and `failed` is tied to 0.

## Structure
- Shared package `pll_sup_pkg`:
  - state enum `pll_sup_state_t`;
  - `RETRY_W`=8;
  - helper function `cnt_width`.
- One sub-module: `sync_2ff`, a generic 1-bit two-flop synchronizer with synchronous reset. It is reused elsewhere for async status inputs.

## Test plan
- Use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8 in all scenarios.
- Nominal lock: `pll_locked` rises 10 cycles after `pll_rst` falls.
  - Expect `pll_rst` high for exactly 4 cycles.
  - Expect `ready`=1 exactly 11 edges after the rise.
  - Expect `retry_count`=0.
- Timeout: `pll_locked` held 0.
  - Expect `pll_rst` to re-pulse every 24 cycles.
  - Expect `retry_count` to step 1, 2, 3, ….
  - Expect `sys_rst` to stay 1.
- Stability glitch: lock, drop `pll_locked` for 3 cycles during STABLE, then relock.
  - Expect a return to WAIT_LOCK without a `pll_rst` pulse.
  - Expect `retry_count` unchanged.
  - Expect `ready` after a fresh 8-cycle qualification.
- Loss in RUN: drop `pll_locked`.
  - Expect `sys_rst`=1, `ready`=0 and `pll_rst`=1 on the 3rd edge.
  - Expect `retry_count`+1.
  - Expect recovery to RUN once lock returns.
- Mid-operation reset: assert `rst` for 1 cycle in RUN.
  - Expect all outputs at reset values on the next edge.
  - Expect `retry_count`=0.
- With the macro and `MAX_RETRIES`=3, hold lock low.
  - Expect `failed`=1 after the 3rd timeout.
  - Expect no further `pll_rst` release.
  - Expect the block to be stuck until `rst`.
